// File: rtl/bep_frame_pkg.sv
// Shared definitions for the BEP thermostat frame.
// Holds field widths, frame length, the encoder state enum and the
// packed frame layout. The struct member order is the on-wire order,
// MSB of the struct first, and is shared with serial_decode.
package bep_frame_pkg;

    localparam int PREAMBLE_W = 32;
    localparam int TYPE_W     = 16;
    localparam int CONSTANT_W = 32;
    localparam int ID_W       = 32;
    localparam int TEMP_W     = 16;
    localparam int STATE_W    = 8;
    localparam int TAIL_W     = 8;
    localparam int FRAME_BITS = 192;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD
    } bep_state_e;

    // Declaration order == transmit order (first member is sent first).
    typedef struct packed {
        logic [PREAMBLE_W-1:0] preamble;
        logic [TYPE_W-1:0]     type_1;
        logic [TYPE_W-1:0]     type_2;
        logic [CONSTANT_W-1:0] constant;
        logic [ID_W-1:0]       thermostat_id;
        logic [TEMP_W-1:0]     room_temp;
        logic [TEMP_W-1:0]     set_temp;
        logic [STATE_W-1:0]    state;
        logic [TAIL_W-1:0]     tail_1;
        logic [TAIL_W-1:0]     tail_2;
        logic [TAIL_W-1:0]     tail_3;
    } bep_frame_t;

endpackage

// File: rtl/bep_frame_encode_half_bit_timer.sv
// half_bit_timer: free-running half-bit cycle counter.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : hold the counter at 0 (used outside SEND)
//   tick           : high on the last cycle of each half-bit
module half_bit_timer #(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = ~clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bep_frame_encode.sv
// bep_frame_encode: latches one BEP frame and sends it MSB-first as an
// IEEE 802.3 Manchester line (bit b -> ~b then b), followed by a guard
// interval at IDLE_LEVEL, then a one-cycle done pulse.
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   start               : request, accepted only in IDLE
//   preamble..tail_3    : frame fields, sampled on acceptance only
//   tx_out              : registered Manchester line
//   busy                : high for the whole frame plus guard
//   done                : one-cycle pulse after the guard
//   bit_index           : index of the bit on the line (191..0), 0 otherwise
module bep_frame_encode
    import bep_frame_pkg::*;
#(
    parameter int   HALF_BIT_CYCLES = 4,
    parameter int   GUARD_HALF_BITS = 8,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] preamble,
    input  logic [15:0] type_1,
    input  logic [15:0] type_2,
    input  logic [31:0] constant,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    input  logic [7:0]  tail_1,
    input  logic [7:0]  tail_2,
    input  logic [7:0]  tail_3,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bit_index
);

    localparam int GUARD_CYC = GUARD_HALF_BITS * HALF_BIT_CYCLES;
    localparam int GRD_W     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYC - 1);

    bep_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  phase_q, phase_d;  // 0: first half (~b), 1: second half (b)
    logic [GRD_W-1:0]      guard_q, guard_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            idx_q, idx_d;
    logic                  tick;
    bep_frame_t            frame_in;

    always_comb begin
        frame_in.preamble      = preamble;
        frame_in.type_1        = type_1;
        frame_in.type_2        = type_2;
        frame_in.constant      = constant;
        frame_in.thermostat_id = thermostat_id;
        frame_in.room_temp     = room_temp;
        frame_in.set_temp      = set_temp;
        frame_in.state         = state;
        frame_in.tail_1        = tail_1;
        frame_in.tail_2        = tail_2;
        frame_in.tail_3        = tail_3;
    end

    // Timer only runs in SEND, so every bit starts with a full half-bit.
    half_bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q != SEND),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        phase_d = phase_q;
        guard_d = guard_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                idx_d  = 8'd0;
                if (start) begin
                    shreg_d = frame_in;
                    state_d = SEND;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 8'(FRAME_BITS - 1);
                    tx_d    = ~preamble[31];
                end
            end
            SEND: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        tx_d    = shreg_q[FRAME_BITS-1];
                    end else if (idx_q == 8'd0) begin
                        phase_d = 1'b0;
                        state_d = GUARD;
                        guard_d = '0;
                        tx_d    = IDLE_LEVEL;
                    end else begin
                        // Next bit's first half is already visible at shreg[190].
                        phase_d = 1'b0;
                        shreg_d = shreg_q << 1;
                        idx_d   = idx_q - 8'd1;
                        tx_d    = ~shreg_q[FRAME_BITS-2];
                    end
                end
            end
            GUARD: begin
                tx_d    = IDLE_LEVEL;
                guard_d = guard_q + GRD_W'(1);
                if (guard_q == GRD_LAST) begin
                    state_d = IDLE;
                    guard_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            phase_q <= 1'b0;
            guard_q <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            phase_q <= phase_d;
            guard_q <= guard_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_index = idx_q;

endmodule

// File: tb/tb_bep_frame_encode.sv
module tb_bep_frame_encode;
  localparam int   H   = 2;
  localparam int   G   = 4;
  localparam int   L   = (384 + G) * H;
  localparam logic IDL = 1'b0;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, start1 = 1'b0;
  logic [31:0] preamble, constant_f, thermostat_id;
  logic [15:0] type_1, type_2, room_temp, set_temp;
  logic [7:0]  state_f, tail_1, tail_2, tail_3;
  logic        tx_out, busy, done, tx1, busy1, done1;
  logic [7:0]  bit_index, idx1;

  int n_chk = 0, n_err = 0;

  always #5 clock = ~clock;

  bep_frame_encode #(.HALF_BIT_CYCLES(H), .GUARD_HALF_BITS(G), .IDLE_LEVEL(IDL)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .preamble(preamble), .type_1(type_1), .type_2(type_2), .constant(constant_f),
    .thermostat_id(thermostat_id), .room_temp(room_temp), .set_temp(set_temp),
    .state(state_f), .tail_1(tail_1), .tail_2(tail_2), .tail_3(tail_3),
    .tx_out(tx_out), .busy(busy), .done(done), .bit_index(bit_index));

  // Edge case: one cycle per half-bit, all-ones frame.
  bep_frame_encode #(.HALF_BIT_CYCLES(1), .GUARD_HALF_BITS(1), .IDLE_LEVEL(IDL)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .preamble('1), .type_1('1), .type_2('1), .constant('1),
    .thermostat_id('1), .room_temp('1), .set_temp('1),
    .state('1), .tail_1('1), .tail_2('1), .tail_3('1),
    .tx_out(tx1), .busy(busy1), .done(done1), .bit_index(idx1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: k = cycles since acceptance (1..L busy, L+1 done cycle, 0 idle).
  int k = 0;
  logic [191:0] mframe;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else if ((k == 0 || k == L + 1) && start) begin
      k <= 1;
      mframe <= {preamble, type_1, type_2, constant_f, thermostat_id,
                 room_temp, set_temp, state_f, tail_1, tail_2, tail_3};
    end
    else if (k == 0 || k == L + 1) k <= 0;
    else k <= k + 1;
  end

  // Returns {tx, busy, done, bit_index}.
  function automatic logic [10:0] expect_out(input int kk, input logic [191:0] fr);
    int hb, bi;
    logic b;
    if (kk == 0)     return {IDL, 1'b0, 1'b0, 8'd0};
    if (kk == L + 1) return {IDL, 1'b0, 1'b1, 8'd0};
    hb = (kk - 1) / H;
    if (hb >= 384)   return {IDL, 1'b1, 1'b0, 8'd0};
    bi = 191 - hb / 2;
    b  = fr[bi];
    return {(hb % 2 == 0) ? ~b : b, 1'b1, 1'b0, 8'(bi)};
  endfunction

  int busy_run = 0, n_done = 0;
  always @(negedge clock) begin
    chk("wave", {21'd0, tx_out, busy, done, bit_index}, {21'd0, expect_out(k, mframe)});
    if (busy) busy_run <= busy_run + 1;
    else if (done) begin
      chk("busy_len", busy_run, L);
      busy_run <= 0;
      n_done <= n_done + 1;
    end else busy_run <= 0;
  end

  task automatic rand_fields();
    preamble = $urandom; type_1 = 16'($urandom); type_2 = 16'($urandom);
    constant_f = $urandom; thermostat_id = $urandom;
    room_temp = 16'($urandom); set_temp = 16'($urandom);
    state_f = 8'($urandom); tail_1 = 8'($urandom); tail_2 = 8'($urandom); tail_3 = 8'($urandom);
  endtask

  task automatic send();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit found = 0;
    for (int i = 0; i < L + 20 && !found; i++) begin
      if (done) found = 1;
      else @(negedge clock);
    end
    chk("wait_done", found, 1);
  endtask

  task automatic wait_idx(input int target);
    bit found = 0;
    for (int i = 0; i < L + 20 && !found; i++) begin
      if (busy && bit_index == 8'(target)) found = 1;
      else @(negedge clock);
    end
    chk("wait_idx", found, 1);
  endtask

  initial begin
    int d0;
    preamble = 0; type_1 = 0; type_2 = 0; constant_f = 0; thermostat_id = 0;
    room_temp = 0; set_temp = 0; state_f = 0; tail_1 = 0; tail_2 = 0; tail_3 = 0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx_out, IDL);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", bit_index, 0);
    chk("rst_dut1", {tx1, busy1, done1, idx1}, {IDL, 10'd0});
    reset_n = 1'b1;
    @(negedge clock);

    // Basic waveform: alternating preamble, zero elsewhere.
    preamble = 32'hAAAA_AAAA;
    send();
    chk("first_half", {tx_out, busy, bit_index}, {1'b0, 1'b1, 8'd191});
    wait_done();

    // Back-to-back: start on the done cycle.
    rand_fields();
    send();
    chk("b2b_busy", busy, 1);
    wait_done();
    @(negedge clock);

    // Random frames; fields changed after acceptance must not matter.
    for (int n = 0; n < 2; n++) begin
      rand_fields();
      send();
      repeat ($urandom_range(10, 300)) @(negedge clock);
      rand_fields();
      wait_done();
      repeat (3) @(negedge clock);
    end

    // Start while busy is ignored.
    rand_fields();
    send();
    wait_idx(150);
    d0 = n_done;
    rand_fields();
    send();
    wait_done();
    repeat (3) @(negedge clock);
    chk("one_done", n_done - d0, 1);

    // Asynchronous reset mid-frame, then a clean frame.
    rand_fields();
    send();
    wait_idx(100);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx", tx_out, IDL);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", bit_index, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    rand_fields();
    send();
    wait_done();
    repeat (3) @(negedge clock);

    // HALF_BIT_CYCLES=1 all ones: 0,1,0,1... for 384 cycles.
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    for (int i = 0; i < 384; i++) begin
      chk("h1_tx", {busy1, tx1}, {1'b1, 1'(i % 2)});
      @(negedge clock);
    end
    chk("h1_guard", {busy1, done1, tx1}, {1'b1, 1'b0, IDL});
    @(negedge clock);
    chk("h1_done", {busy1, done1}, 2'b01);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bep_frame_encode.md
Name: bep_frame_encode

Overview:
- Transmit-side counterpart of the thermostat BEP frame receiver. Latches one full frame of field values and serialises it MSB-first as a Manchester-encoded line.
- The waveform is directly consumable by the existing edge-detect / state-machine / serial-decode receive chain. It is used as an on-chip loopback source and as a standalone transmitter on a spare output pin.

Parameters:
- HALF_BIT_CYCLES, 4: clock cycles per Manchester half-bit; legal range is 1 or more.
- GUARD_HALF_BITS, 8: idle half-bits driven after the last data bit, before done; legal range is 1 or more.
- IDLE_LEVEL, 1'b0: line level while idle and during the guard interval.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- preamble  in  32  frame field
- type_1  in  16  frame field
- type_2  in  16  frame field
- constant  in  32  frame field
- thermostat_id  in  32  frame field
- room_temp  in  16  frame field
- set_temp  in  16  frame field
- state  in  8  frame field
- tail_1  in  8  frame field
- tail_2  in  8  frame field
- tail_3  in  8  frame field
- tx_out  out  1  Manchester line
- busy  out  1  high from the cycle after acceptance through the last guard cycle
- done  out  1  one-cycle pulse when the frame completes
- bit_index  out  8  index of the bit currently on the line, counting down 191..0; 0 when idle

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state=IDLE, tx_out=IDLE_LEVEL, busy=0, done=0, bit_index=0, counters=0. The shift register contents are don't-care.
- Frame layout: 192 bits, MSB of each field first, fields in this order: preamble, type_1, type_2, constant, thermostat_id, room_temp, set_temp, state, tail_1, tail_2, tail_3. The first bit sent is preamble[31]; the last is tail_3[0].
- Encoding (IEEE 802.3): bit b drives ~b for the first half-bit and b for the second. A 1 is therefore low-to-high at mid-bit; a 0 is high-to-low.
- Each half-bit lasts exactly HALF_BIT_CYCLES cycles. The line has no glitches, and tx_out is a registered output.
- IDLE:
  - tx_out=IDLE_LEVEL.
  - If start=1 at edge t: all fields are loaded into a 192-bit shift register, the half-bit counter is cleared, and the state moves to SEND.
  - From cycle t+1: busy=1, tx_out = ~preamble[31], bit_index=191.
- SEND:
  - The half-cycle counter counts 0..HALF_BIT_CYCLES-1, and a phase flag selects the first or second half.
  - At the end of the second half, the register shifts left and bit_index decrements.
  - After the second half of bit 0, the state moves to GUARD.
- GUARD:
  - tx_out=IDLE_LEVEL for GUARD_HALF_BITS*HALF_BIT_CYCLES cycles.
  - Then the state moves to IDLE, with busy=0 and done=1 for exactly that one cycle.
- Total busy duration: (384 + GUARD_HALF_BITS) * HALF_BIT_CYCLES cycles.
- start while busy=1 is ignored: no queuing, no restart, field inputs not sampled.
- start on the done cycle (state is IDLE) is accepted, so back-to-back frames are separated only by the guard interval.
- Field inputs may change freely after acceptance; the transmitted frame uses only the values latched at acceptance.
- Counters use unsigned arithmetic. The half-bit counter is sized as clog2(HALF_BIT_CYCLES) with a minimum of 1 bit. The guard counter is sized from GUARD_HALF_BITS*HALF_BIT_CYCLES. No counter wraps within a state.

Decomposition:
- Shared package bep_frame_pkg holds:
  - the field width constants (PREAMBLE_W=32, TYPE_W=16, CONSTANT_W=32, ID_W=32, TEMP_W=16, STATE_W=8, TAIL_W=8) and FRAME_BITS=192;
  - the state enum {IDLE, SEND, GUARD};
  - the field-order definition, which is reused by serial_decode.
- One sub-module: half_bit_timer (parameter HALF_BIT_CYCLES; inputs clock, reset_n, clear; output a tick pulse on the last cycle of each half-bit). The FSM and shift register stay in the parent.

Test Plan:
- Reset mid-frame: assert reset_n=0 at bit_index=100 -> tx_out=IDLE_LEVEL, busy=0 and done=0 immediately (same cycle, asynchronous); release reset and start -> a full clean frame is sent.
- Basic waveform, with HALF_BIT_CYCLES=2, GUARD_HALF_BITS=4, preamble=0xAAAAAAAA, all other fields 0:
  - tx_out from t+1 is 0,0,1,1, 1,1,0,0, repeating for the preamble.
  - Then 1,1,0,0 for every zero bit.
  - busy lasts exactly 776 cycles; done pulses once at cycle t+777.
- Loopback: encoder tx_out driven into the receiver top with preamble=0xAAAAAAAA, thermostat_id=0x12345678, room_temp=0x00D2, set_temp=0x00DC, state=0x03, all other fields 0xFF/0xFFFF/0xFFFFFFFF -> the decoder outputs match bit-for-bit after full.
- Start ignored while busy: pulse start at bit_index=150 with different fields -> the waveform continues unchanged, busy length is unchanged, and only one done pulse occurs.
- Back-to-back: start asserted on the done cycle -> busy rises on the next cycle, and the inter-frame IDLE_LEVEL gap is exactly GUARD_HALF_BITS*HALF_BIT_CYCLES+1 cycles.
- Edge parameter: HALF_BIT_CYCLES=1, frame of all ones -> tx_out alternates 0,1 every cycle for 384 cycles, with no stuck or missing half-bit at bit boundaries.
